// File: rtl/fp_defs.sv
// fp_defs: shared encodings and binary32 field constants for the sequenced FP adder.
package fp_defs;
  localparam int SIGN = 1;
  localparam int EXP = 8;
  localparam int FRAC = 23;
  localparam int MANT = 24;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
  } state_t;
endpackage

// File: rtl/count_leading_zeros.sv
// count_leading_zeros: leading-zero count of a 24-bit mantissa (24 when all zero).
module count_leading_zeros
  import fp_defs::*;
(
  input  logic [MANT-1:0] m_i,
  output logic [4:0]      lz_o
);
  always_comb begin
    lz_o = 5'd24;
    for (int i = 0; i < MANT; i++) lz_o = m_i[i] ? 5'(MANT - 1 - i) : lz_o;
  end
endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle binary32 adder, one operation in flight, truncating.
module fp_add_sequencer
  import fp_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, spec_q, spec_d, result_q, result_d;
  logic [MANT-1:0] ma_q, ma_d, mb_q, mb_d, mant_q, mant_d;
  logic [EXP-1:0] d_q, d_d;
  logic signed [9:0] exp_q, exp_d, lz_s;
  logic sign_q, sign_d, sub_q, sub_d, special_q, special_d, zero_q, zero_d, flush_q, flush_d;
  logic [4:0] lz;
  logic swap, nan, inf_a, inf_b;
  logic [31:0] x, y;
  logic [MANT:0] sum;
  logic [MANT-1:0] madd;
  assign in_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign result = result_q;
  // Larger magnitude goes to x so alignment only ever shifts y right
  assign swap = b_q[30:0] > a_q[30:0];
  assign x = swap ? b_q : a_q;
  assign y = swap ? a_q : b_q;
  assign inf_a = a_q[30:FRAC] == 8'hFF && a_q[FRAC-1:0] == '0;
  assign inf_b = b_q[30:FRAC] == 8'hFF && b_q[FRAC-1:0] == '0;
  assign nan = (a_q[30:FRAC] == 8'hFF && a_q[FRAC-1:0] != '0) || (b_q[30:FRAC] == 8'hFF && b_q[FRAC-1:0] != '0);
  assign sum = {1'b0, ma_q} + {1'b0, mb_q};
  assign madd = sub_q ? ma_q - mb_q : sum[MANT] ? sum[MANT:1] : sum[MANT-1:0];
  assign lz_s = {5'd0, lz};
  count_leading_zeros u_clz (.m_i(mant_q), .lz_o(lz));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    spec_d = spec_q;
    result_d = result_q;
    ma_d = ma_q;
    mb_d = mb_q;
    mant_d = mant_q;
    d_d = d_q;
    exp_d = exp_q;
    sign_d = sign_q;
    sub_d = sub_q;
    special_d = special_q;
    zero_d = zero_q;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        state_d = in_valid ? S_UNPACK : S_IDLE;
        a_d = in_valid ? a : a_q;
        b_d = in_valid ? b : b_q;
      end
      S_UNPACK: begin
        state_d = S_ALIGN;
        sign_d = x[31];
        sub_d = x[31] ^ y[31];
        exp_d = {2'b00, x[30:FRAC]};
        ma_d = x[30:FRAC] == '0 ? '0 : {1'b1, x[FRAC-1:0]};
        mb_d = y[30:FRAC] == '0 ? '0 : {1'b1, y[FRAC-1:0]};
        d_d = x[30:FRAC] - y[30:FRAC];
        special_d = nan || inf_a || inf_b;
        spec_d = (nan || (inf_a && inf_b && (a_q[31] ^ b_q[31]))) ? QNAN : {x[31], 8'hFF, 23'd0};
        zero_d = 1'b0;
        flush_d = 1'b0;
      end
      S_ALIGN: begin
        state_d = S_ADD;
        mb_d = d_q >= 8'd24 ? '0 : mb_q >> d_q;
      end
      S_ADD: begin
        state_d = S_NORM;
        mant_d = madd;
        exp_d = exp_q + {9'd0, ~sub_q & sum[MANT]};
        zero_d = madd == '0;
      end
      S_NORM: begin
        state_d = S_PACK;
        flush_d = !zero_q && exp_q <= lz_s;
        mant_d = (!zero_q && exp_q > lz_s) ? mant_q << lz : mant_q;
        exp_d = (!zero_q && exp_q > lz_s) ? exp_q - lz_s : exp_q;
      end
      S_PACK: begin
        state_d = S_DONE;
        result_d = special_q ? spec_q :
                   zero_q ? 32'd0 :
                   flush_q ? {sign_q, 31'd0} :
                   int'(exp_q) >= EXP_MAX ? {sign_q, 8'hFF, 23'd0} :
                   {sign_q, exp_q[EXP-1:0], mant_q[FRAC-1:0]};
      end
      S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      spec_q <= '0;
      result_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
      mant_q <= '0;
      d_q <= '0;
      exp_q <= '0;
      sign_q <= 1'b0;
      sub_q <= 1'b0;
      special_q <= 1'b0;
      zero_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      spec_q <= spec_d;
      result_q <= result_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      mant_q <= mant_d;
      d_q <= d_d;
      exp_q <= exp_d;
      sign_q <= sign_d;
      sub_q <= sub_d;
      special_q <= special_d;
      zero_q <= zero_d;
      flush_q <= flush_d;
    end
  end
endmodule
